// File: rtl/feature_packet_rx_pkg.sv
// feature_packet_rx_pkg: wire-format constants and shared types for the feature packet link
package feature_packet_rx_pkg;

    localparam logic [7:0] HDR_BYTE       = 8'hF0;
    localparam int         MAX_FEAT       = 36;
    localparam int         BYTES_PER_FEAT = 8;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_COUNT   = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_code_t;

    typedef enum logic [1:0] {
        HUNT,
        COUNT,
        DATA,
        DISCARD
    } state_t;

endpackage

// File: rtl/feature_packet_rx_timeout_ctr.sv
// rx_timeout_ctr: inter-byte idle counter that pulses expire on its last count
module rx_timeout_ctr #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int           W    = $clog2(CYCLES) + 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    assign expire = en && cnt == LAST;

    // count idle cycles while enabled, restart on clear or after expiring
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr || expire) cnt <= '0;
        else if (en) cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/feature_packet_rx.sv
// feature_packet_rx: parses F0-framed feature packets from a UART RX FIFO into committed coordinate arrays
module feature_packet_rx #(
    parameter int MAX_FEAT       = feature_packet_rx_pkg::MAX_FEAT,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fifo_empty,
    input  logic [7:0]              fifo_din,
    output logic                    fifo_rd_en,
    output logic                    pkt_valid,
    output logic [5:0]              pkt_count,
    output logic [32*MAX_FEAT-1:0]  feat_x,
    output logic [32*MAX_FEAT-1:0]  feat_y,
    output logic                    err_valid,
    output logic [1:0]              err_code
);

    import feature_packet_rx_pkg::*;

    localparam logic [7:0] MAX_B  = 8'(MAX_FEAT);
    localparam logic [2:0] LAST_B = 3'(BYTES_PER_FEAT - 1);

    state_t      state, state_nx;
    logic        run, byte_valid, expire, take, commit, err_cnt, rec_end;
    logic [5:0]  cnt, feat_idx;
    logic [2:0]  byte_idx;
    logic [31:0] shadow_x [MAX_FEAT];
    logic [31:0] shadow_y [MAX_FEAT];

    // run holds reads off for the first cycle after reset release
    assign fifo_rd_en = run & ~fifo_empty;
    // a byte arriving together with a timeout is dropped
    assign take    = byte_valid & ~expire;
    assign rec_end = byte_idx == LAST_B;

    rx_timeout_ctr #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (byte_valid || state == HUNT),
        .en     (state != HUNT),
        .expire (expire)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else state <= state_nx;
    end

    // next state, commit and count-error decode
    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        err_cnt  = 1'b0;
        if (expire) state_nx = HUNT;
        else if (byte_valid)
            case (state)
                HUNT: state_nx = (fifo_din == HDR_BYTE) ? COUNT : HUNT;
                COUNT: begin
                    err_cnt  = fifo_din > MAX_B;
                    state_nx = (fifo_din == 8'd0) ? DISCARD : err_cnt ? HUNT : DATA;
                end
                DATA: begin
                    commit   = rec_end && feat_idx == cnt - 6'd1;
                    state_nx = commit ? HUNT : DATA;
                end
                default: begin
                    commit   = rec_end;
                    state_nx = commit ? HUNT : DISCARD;
                end
            endcase
    end

    // byte capture, shadow fill, commit and error reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            byte_valid <= 1'b0;
            pkt_valid  <= 1'b0;
            err_valid  <= 1'b0;
            err_code   <= ERR_NONE;
            pkt_count  <= '0;
            feat_x     <= '0;
            feat_y     <= '0;
            cnt        <= '0;
            feat_idx   <= '0;
            byte_idx   <= '0;
            for (int i = 0; i < MAX_FEAT; i++) begin
                shadow_x[i] <= '0;
                shadow_y[i] <= '0;
            end
        end else begin
            run        <= 1'b1;
            byte_valid <= fifo_rd_en;
            pkt_valid  <= commit;
            err_valid  <= expire | err_cnt;
            if (expire) err_code <= ERR_TIMEOUT;
            else if (err_cnt) err_code <= ERR_COUNT;
            if (take && state == COUNT) begin
                cnt      <= fifo_din[5:0];
                feat_idx <= '0;
                byte_idx <= '0;
            end
            if (take && (state == DATA || state == DISCARD)) begin
                byte_idx <= byte_idx + 3'd1;
                if (rec_end) feat_idx <= feat_idx + 6'd1;
            end
            if (take && state == DATA) begin
                if (!byte_idx[2]) shadow_x[feat_idx][{byte_idx[1:0], 3'b000} +: 8] <= fifo_din;
                else shadow_y[feat_idx][{byte_idx[1:0], 3'b000} +: 8] <= fifo_din;
            end
            // the final byte is merged straight into the outputs so commit lands one cycle after it
            if (commit) begin
                pkt_count <= cnt;
                for (int i = 0; i < MAX_FEAT; i++)
                    if (6'(i) < cnt) begin
                        feat_x[32*i +: 32] <= shadow_x[i];
                        feat_y[32*i +: 32] <= (6'(i) == feat_idx) ? {fifo_din, shadow_y[i][23:0]} : shadow_y[i];
                    end
            end
        end
    end

endmodule

// File: tb/tb_feature_packet_rx.sv
// tb_feature_packet_rx: directed scenarios for the feature packet receiver
module tb_feature_packet_rx;

    localparam int NF = 36;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fifo_empty;
    logic [7:0]       fifo_din = 8'h00;
    logic             fifo_rd_en;
    logic             pkt_valid;
    logic [5:0]       pkt_count;
    logic [32*NF-1:0] feat_x;
    logic [32*NF-1:0] feat_y;
    logic             err_valid;
    logic [1:0]       err_code;

    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int total  = 0;
    int bad    = 0;

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after the read strobe
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk)
        if (fifo_rd_en) begin
            fifo_din <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1;
        end

    feature_packet_rx #(.MAX_FEAT(NF), .TIMEOUT_CYCLES(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_din   (fifo_din),
        .fifo_rd_en (fifo_rd_en),
        .pkt_valid  (pkt_valid),
        .pkt_count  (pkt_count),
        .feat_x     (feat_x),
        .feat_y     (feat_y),
        .err_valid  (err_valid),
        .err_code   (err_code)
    );

    function automatic logic [31:0] getx(int i);
        return feat_x[32*i +: 32];
    endfunction

    function automatic logic [31:0] gety(int i);
        return feat_y[32*i +: 32];
    endfunction

    function automatic logic [31:0] vx(int i);
        logic [7:0] a = 8'(i);
        return {a, a + 8'h40, 8'hF0, 8'hFF - a};
    endfunction

    function automatic logic [31:0] vy(int i);
        return 32'(-(i + 1) * 65536);
    endfunction

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic push32(input logic [31:0] v);
        for (int k = 0; k < 4; k++) push(v[8*k +: 8]);
    endtask

    task automatic run_cycles(input int n, output int pv, output int ev);
        pv = 0;
        ev = 0;
        repeat (n) begin
            @(negedge clk);
            pv += int'(pkt_valid);
            ev += int'(err_valid);
        end
    endtask

    task automatic drain(output int cycles, output bit ok);
        cycles = 0;
        while (rd_ptr != wr_ptr && cycles < 1000) begin
            @(negedge clk);
            cycles++;
        end
        ok = (rd_ptr == wr_ptr);
    endtask

    task automatic test_reset;
        push(8'h00);
        repeat (2) @(negedge clk);
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL reset_pkt_valid got=%b exp=0", pkt_valid); end
        total++; if (err_valid !== 1'b0) begin bad++; $display("FAIL reset_err_valid got=%b exp=0", err_valid); end
        total++; if (err_code !== 2'b00) begin bad++; $display("FAIL reset_err_code got=%b exp=00", err_code); end
        total++; if (pkt_count !== 6'd0) begin bad++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
        total++; if (feat_x !== '0 || feat_y !== '0) begin bad++; $display("FAIL reset_feat got nonzero exp=0"); end
        rst_n = 1'b1;
    endtask

    task automatic test_two_feat;
        int pv, ev;
        push(8'hF0); push(8'h02);
        push32(32'h0001_0000); push32(32'hFFFF_0000);
        push32(32'h1234_5678); push32(32'h0000_0001);
        run_cycles(30, pv, ev);
        total++; if (pv !== 1) begin bad++; $display("FAIL two_pkt_pulses got=%0d exp=1", pv); end
        total++; if (ev !== 0) begin bad++; $display("FAIL two_err_pulses got=%0d exp=0", ev); end
        total++; if (pkt_count !== 6'd2) begin bad++; $display("FAIL two_count got=%0d exp=2", pkt_count); end
        total++; if ($signed(getx(0)) !== 32'sd65536) begin bad++; $display("FAIL two_x0 got=%h exp=00010000", getx(0)); end
        total++; if ($signed(gety(0)) !== -32'sd65536) begin bad++; $display("FAIL two_y0 got=%h exp=ffff0000", gety(0)); end
        total++; if (getx(1) !== 32'h1234_5678) begin bad++; $display("FAIL two_x1 got=%h exp=12345678", getx(1)); end
        total++; if (gety(1) !== 32'h0000_0001) begin bad++; $display("FAIL two_y1 got=%h exp=00000001", gety(1)); end
        total++; if (getx(2) !== 32'h0) begin bad++; $display("FAIL two_x2 got=%h exp=00000000", getx(2)); end
    endtask

    task automatic test_zero_count;
        int pv, ev;
        push(8'h55); push(8'hAA); push(8'hF0); push(8'h00);
        push32(32'h3322_11F0); push32(32'h7766_5544);
        run_cycles(30, pv, ev);
        total++; if (pv !== 1) begin bad++; $display("FAIL zero_pkt_pulses got=%0d exp=1", pv); end
        total++; if (pkt_count !== 6'd0) begin bad++; $display("FAIL zero_count got=%0d exp=0", pkt_count); end
        total++; if (getx(0) !== 32'h0001_0000 || gety(1) !== 32'h1) begin bad++; $display("FAIL zero_keep got x0=%h y1=%h exp=00010000 00000001", getx(0), gety(1)); end
        push(8'hF0); push(8'h01);
        push32(32'hDEAD_BEEF); push32(32'h8000_0000);
        run_cycles(20, pv, ev);
        total++; if (pv !== 1) begin bad++; $display("FAIL zero_next_pulses got=%0d exp=1", pv); end
        total++; if (pkt_count !== 6'd1) begin bad++; $display("FAIL zero_next_count got=%0d exp=1", pkt_count); end
        total++; if (getx(0) !== 32'hDEAD_BEEF || gety(0) !== 32'h8000_0000) begin bad++; $display("FAIL zero_next_rec got=%h/%h exp=deadbeef/80000000", getx(0), gety(0)); end
        total++; if (getx(1) !== 32'h1234_5678) begin bad++; $display("FAIL zero_next_keep got=%h exp=12345678", getx(1)); end
    endtask

    task automatic test_count_err;
        int pv, ev;
        push(8'hF0); push(8'h25);
        run_cycles(10, pv, ev);
        total++; if (ev !== 1) begin bad++; $display("FAIL cnt_err_pulses got=%0d exp=1", ev); end
        total++; if (pv !== 0) begin bad++; $display("FAIL cnt_err_pkt got=%0d exp=0", pv); end
        total++; if (err_code !== 2'b01) begin bad++; $display("FAIL cnt_err_code got=%b exp=01", err_code); end
        push(8'hF0); push(8'h01);
        push32(32'h00F0_F0F0); push32(32'h7FFF_FFFF);
        run_cycles(20, pv, ev);
        total++; if (pv !== 1 || ev !== 0) begin bad++; $display("FAIL cnt_err_next got pkt=%0d err=%0d exp=1 0", pv, ev); end
        total++; if (getx(0) !== 32'h00F0_F0F0 || gety(0) !== 32'h7FFF_FFFF) begin bad++; $display("FAIL cnt_err_rec got=%h/%h exp=00f0f0f0/7fffffff", getx(0), gety(0)); end
    endtask

    task automatic test_timeout;
        int n, c;
        bit ok;
        push(8'hF0); push(8'h03);
        push32(32'h1111_1111); push32(32'h2222_2222);
        push(8'h33); push(8'h44);
        drain(c, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL to_drain got=%0d exp=%0d", rd_ptr, wr_ptr); end
        // the last byte is consumed on the next edge, the error lands 100 cycles after that
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL to_pkt got=%b exp=0", pkt_valid); end
            if (err_valid) begin n = k; break; end
        end
        total++; if (n !== 101) begin bad++; $display("FAIL to_latency got=%0d exp=101", n); end
        total++; if (err_code !== 2'b10) begin bad++; $display("FAIL to_code got=%b exp=10", err_code); end
        @(negedge clk);
        total++; if (err_valid !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b exp=0", err_valid); end
        total++; if (pkt_count !== 6'd1 || getx(0) !== 32'h00F0_F0F0) begin bad++; $display("FAIL to_keep got=%0d/%h exp=1/00f0f0f0", pkt_count, getx(0)); end
    endtask

    task automatic test_back_to_back;
        int n, c, gaps;
        bit ok;
        push(8'hF0); push(8'(NF));
        for (int i = 0; i < NF; i++) begin push32(vx(i)); push32(vy(i)); end
        gaps = 0;
        c = 0;
        while (rd_ptr != wr_ptr && c < 1000) begin
            @(negedge clk);
            c++;
            if (rd_ptr != wr_ptr && fifo_rd_en !== 1'b1) gaps++;
        end
        ok = (rd_ptr == wr_ptr);
        total++; if (!ok || c !== 290) begin bad++; $display("FAIL b2b_stream got=%0d exp=290", c); end
        total++; if (gaps !== 0) begin bad++; $display("FAIL b2b_rd_en got=%0d gaps exp=0", gaps); end
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (pkt_valid) begin n = k; break; end
        end
        total++; if (n !== 1) begin bad++; $display("FAIL b2b_latency got=%0d exp=1", n); end
        total++; if (pkt_count !== 6'd36) begin bad++; $display("FAIL b2b_count got=%0d exp=36", pkt_count); end
        for (int i = 0; i < NF; i++) begin
            total++; if (getx(i) !== vx(i)) begin bad++; $display("FAIL b2b_x%0d got=%h exp=%h", i, getx(i), vx(i)); end
            total++; if (gety(i) !== vy(i)) begin bad++; $display("FAIL b2b_y%0d got=%h exp=%h", i, gety(i), vy(i)); end
        end
    endtask

    task automatic test_reset_mid;
        int pv, ev, c;
        bit ok;
        push(8'hF0); push(8'h02);
        push32(32'hAAAA_AAAA); push(8'hBB);
        drain(c, ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (pkt_count !== 6'd0 || err_code !== 2'b00) begin bad++; $display("FAIL rstm_regs got=%0d/%b exp=0/00", pkt_count, err_code); end
        total++; if (feat_x !== '0 || feat_y !== '0) begin bad++; $display("FAIL rstm_feat got nonzero exp=0"); end
        total++; if (fifo_rd_en !== 1'b0 || pkt_valid !== 1'b0 || err_valid !== 1'b0) begin bad++; $display("FAIL rstm_strobes got=%b%b%b exp=000", fifo_rd_en, pkt_valid, err_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(8'hF0); push(8'h01);
        push32(32'hCAFE_F00D); push32(32'h0000_0042);
        run_cycles(20, pv, ev);
        total++; if (pv !== 1 || ev !== 0) begin bad++; $display("FAIL rstm_pulses got pkt=%0d err=%0d exp=1 0", pv, ev); end
        total++; if (getx(0) !== 32'hCAFE_F00D || gety(0) !== 32'h42) begin bad++; $display("FAIL rstm_rec got=%h/%h exp=cafef00d/00000042", getx(0), gety(0)); end
        total++; if (getx(1) !== 32'h0 || pkt_count !== 6'd1) begin bad++; $display("FAIL rstm_rest got=%h/%0d exp=00000000/1", getx(1), pkt_count); end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset;
        test_two_feat;
        test_zero_count;
        test_count_err;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/feature_packet_rx.md
FEATURE_PACKET_RX -- requirements
Module: feature_packet_rx

Interface
REQ-001 Parameter MAX_FEAT, default 36, is the maximum feature records per packet.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000, is the inter-byte timeout in clk cycles.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 fifo_empty  input  1  UART RX FIFO empty flag.
REQ-006 fifo_din  input  8  RX FIFO read data, valid the cycle after fifo_rd_en.
REQ-007 fifo_rd_en  output  1  RX FIFO read strobe.
REQ-008 pkt_valid  output  1  one-cycle pulse, new packet committed to the feature outputs.
REQ-009 pkt_count  output  6  feature count of the last committed packet.
REQ-010 feat_x  output  signed 32 x MAX_FEAT  committed X coordinates, Q16.16 mm.
REQ-011 feat_y  output  signed 32 x MAX_FEAT  committed Y coordinates, Q16.16 mm.
REQ-012 err_valid  output  1  one-cycle error pulse.
REQ-013 err_code  output  2  01 = count > MAX_FEAT, 10 = timeout; held until next error.

Function
REQ-014 Wire format: 0xF0 header, count byte, then count records of 8 bytes: x[7:0], x[15:8], x[23:16], x[31:24], y[7:0] .. y[31:24] (little-endian).
REQ-015 When count == 0, the transmitter emits exactly one 8-byte dummy record; the receiver discards it and commits a zero-feature packet.
REQ-016 fifo_rd_en = !fifo_empty every cycle out of reset (back-to-back reads); byte_valid is fifo_rd_en registered; fifo_din is consumed only when byte_valid = 1.
REQ-017 States: HUNT, COUNT, DATA, DISCARD; reset state HUNT.
REQ-018 HUNT: byte 0xF0 -> COUNT; any other byte is dropped and the state stays HUNT.
REQ-019 COUNT: byte == 0 -> DISCARD; 1..MAX_FEAT -> DATA with feat_idx = 0, byte_idx = 0; > MAX_FEAT -> err_valid, err_code = 01, HUNT.
REQ-020 DATA: byte_idx 0..7 selects the target byte lane of shadow_x/shadow_y[feat_idx].
REQ-021 DATA: after byte_idx 7, feat_idx increments; after the last byte of record count-1, the packet commits and the state returns to HUNT.
REQ-022 DISCARD: consumes 8 bytes, then commits with count 0 and returns to HUNT.
REQ-023 Commit, in one cycle: feat_x/feat_y <= shadow arrays, pkt_count <= count, and pkt_valid = 1 in the cycle after the final byte_valid.
REQ-024 Entries at index >= count keep their previous committed values.
REQ-025 Feature outputs change only on commit; partial packets are never visible.
REQ-026 A 0xF0 byte in DATA is data, not a resync.
REQ-027 Timeout: the counter resets on every byte_valid and runs only outside HUNT.
REQ-028 Timeout: reaching TIMEOUT_CYCLES-1 -> err_valid, err_code = 10, HUNT, shadow discarded.
REQ-029 Timeout takes priority over a byte_valid arriving in the same cycle; that byte is dropped.
REQ-030 Exactly one of pkt_valid/err_valid may pulse per cycle.

Reset
REQ-031 rst_n low asynchronously forces: state HUNT, fifo_rd_en 0, byte_valid 0, pkt_valid 0, err_valid 0, err_code 00, pkt_count 0, all feat_x/feat_y 0, shadow arrays 0, counters 0.
REQ-032 Reset mid-packet abandons the packet with no commit; the first byte after release is parsed in HUNT.
REQ-033 rst_n deassertion is synchronised externally; no internal synchroniser.

Structure
REQ-034 The shared package holds HDR_BYTE = 8'hF0, MAX_FEAT, BYTES_PER_FEAT = 8, the err_code enum and the state enum; the transmitter uses the same package.
REQ-035 One sub-module, rx_timeout_ctr (parameterised counter: clear, enable, expire pulse), is instantiated once.

Verification
REQ-036 Bytes F0 02 + records (x=0x00010000, y=0xFFFF0000), (x=0x12345678, y=0x00000001) -> pkt_valid once; pkt_count=2; feat_x[0]=65536, feat_y[0]=-65536, feat_x[1]=0x12345678, feat_y[1]=1.
REQ-037 Bytes 55 AA F0 00 + 8 arbitrary bytes -> pkt_valid, pkt_count=0, feat arrays unchanged; next F0 01 + record parses correctly.
REQ-038 Bytes F0 25 -> err_valid with err_code=01, no pkt_valid; following F0 01 + record commits normally.
REQ-039 Bytes F0 03 + 10 bytes, then idle TIMEOUT_CYCLES (set to 100) -> err_valid with code 10 at cycle 100 after the last byte; outputs unchanged.
REQ-040 Full 36-feature packet streamed back-to-back with fifo_empty=0 -> fifo_rd_en held high, pkt_valid 1 cycle after the last byte, all 72 words correct.
REQ-041 rst_n pulsed low mid-DATA -> all outputs 0 asynchronously; a fresh packet after release decodes correctly.
